booth_control: RTL and testbench

Sequencing control unit for the radix-2 Booth multiplier. It sits directly upstream of the A/Q shift registers and the adder/subtractor, and drives their load, shift and subtract lines. It takes a start request and the two Booth test bits (Q0, Q-1) and steps the datapath through load, add/subtract and arithmetic-shift iterations. It signals completion with `done`.

---
 rtl/booth_pkg.sv | 19 +
 rtl/booth_iter_cnt.sv | 35 +++
 rtl/booth_control.sv | 136 +++++++++++++
 tb/tb_booth_control.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier control slice:
// one-hot state codes, default iteration count and op-flag encoding.
package booth_pkg;

  localparam int unsigned ITER_DEFAULT = 3;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [5:0] {
    StIdle  = 6'b000001,
    StLoad  = 6'b000010,
    StTest  = 6'b000100,
    StArith = 6'b001000,
    StShift = 6'b010000,
    StFin   = 6'b100000
  } state_e;

endpackage

// File: rtl/booth_iter_cnt.sv
// Booth iteration counter: synchronous clear, increment enable, and a
// terminal flag raised on the final iteration (count == ITER-1).
module booth_iter_cnt #(
  parameter int unsigned ITER = 3,
  parameter int unsigned CW   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CW'(ITER - 1));

endmodule

// File: rtl/booth_control.sv
// Moore sequencer for the radix-2 Booth multiplier datapath.
// Define BOOTH_DONE_HOLD_EN to keep done high from FIN until the next LOAD.
module booth_control
  import booth_pkg::*;
#(
  parameter int unsigned ITER = ITER_DEFAULT,
  parameter int unsigned CW   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q0,
  input  logic q_1,
  output logic carga_m,
  output logic carga_q,
  output logic carga_a,
  output logic sel_suma,
  output logic resta,
  output logic desplaza,
  output logic clr_q1,
  output logic busy,
  output logic done
);

  state_e state_q, state_d;
  logic   op_q, op_d;
  logic   cnt_clr, cnt_inc, cnt_last;
  logic   fin_done;

  booth_iter_cnt #(
    .ITER(ITER),
    .CW  (CW)
  ) u_iter_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .last_o(cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    carga_m  = 1'b0;
    carga_q  = 1'b0;
    carga_a  = 1'b0;
    sel_suma = 1'b0;
    resta    = 1'b0;
    desplaza = 1'b0;
    clr_q1   = 1'b0;
    fin_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        carga_m = 1'b1;
        carga_q = 1'b1;
        carga_a = 1'b1;
        clr_q1  = 1'b1;
        cnt_clr = 1'b1;
        state_d = StTest;
      end
      StTest: begin
        unique case ({q0, q_1})
          2'b10: begin
            op_d    = OP_SUB;
            state_d = StArith;
          end
          2'b01: begin
            op_d    = OP_ADD;
            state_d = StArith;
          end
          default: state_d = StShift;
        endcase
      end
      StArith: begin
        carga_a  = 1'b1;
        sel_suma = 1'b1;
        resta    = op_q;
        state_d  = StShift;
      end
      StShift: begin
        desplaza = 1'b1;
        cnt_inc  = 1'b1;
        state_d  = cnt_last ? StFin : StTest;
      end
      StFin: begin
        fin_done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

`ifdef BOOTH_DONE_HOLD_EN
  logic hold_q, hold_d;

  // Set on leaving FIN, cleared on entering LOAD so done is low in LOAD.
  always_comb begin
    hold_d = hold_q;
    if (state_q == StFin) begin
      hold_d = 1'b1;
    end else if (state_d == StLoad) begin
      hold_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign done = fin_done | hold_q;
`else
  assign done = fin_done;
`endif

endmodule

// File: tb/tb_booth_control.sv
// Self-checking bench for booth_control: directed Booth bit patterns plus
// random multiplications through a behavioural A:Q:Q-1 datapath model.
module tb_booth_control;

  localparam int unsigned N = 3;

`ifdef BOOTH_DONE_HOLD_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif

  logic clk, reset, start, q0, q_1;
  logic carga_m, carga_q, carga_a, sel_suma, resta, desplaza, clr_q1, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus source: forced per-iteration {q0,q_1} table or datapath model.
  logic           use_dp;
  logic [2*N-1:0] fpat;
  logic [1:0]     fpair;
  int             fidx;
  logic [N-1:0]   a_in, b_in;
  logic [N:0]     dp_a, dp_m;
  logic [N-1:0]   dp_q;
  logic           dp_q1;

  booth_control #(
    .ITER(N),
    .CW  (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .q0      (q0),
    .q_1     (q_1),
    .carga_m (carga_m),
    .carga_q (carga_q),
    .carga_a (carga_a),
    .sel_suma(sel_suma),
    .resta   (resta),
    .desplaza(desplaza),
    .clr_q1  (clr_q1),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb fpair = (fidx < int'(N)) ? fpat[2*fidx +: 2] : 2'b00;
  assign q0  = use_dp ? dp_q[0] : fpair[1];
  assign q_1 = use_dp ? dp_q1   : fpair[0];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_a <= '0; dp_m <= '0; dp_q <= '0; dp_q1 <= 1'b0; fidx <= 0;
    end else begin
      if (carga_m) dp_m <= {a_in[N-1], a_in};
      if (carga_q) dp_q <= b_in;
      if (clr_q1) dp_q1 <= 1'b0;
      if (carga_a) dp_a <= sel_suma ? (resta ? dp_a - dp_m : dp_a + dp_m) : '0;
      if (desplaza) {dp_a, dp_q, dp_q1} <= {dp_a[N], dp_a, dp_q};
      if (carga_m) fidx <= 0;
      else if (desplaza) fidx <= fidx + 1;
    end
  end

  function automatic logic [8:0] all_outs();
    return {carga_m, carga_q, carga_a, sel_suma, resta, desplaza, clr_q1, busy, done};
  endfunction

  // One multiplication: expected latency and op sequence come from the Booth
  // recoding of the per-iteration bit pairs.
  task automatic do_run(input string name, input logic dp, input logic [2*N-1:0] pat_in,
                        input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic extra, input logic b2b);
    int c, nsh, nar, exp_lat, prod, eprod, wait_c;
    int exp_ops[$];
    logic [2*N-1:0] pat;
    logic [1:0] pr;
    logic seen;
    pat = pat_in;
    if (dp) begin
      for (int i = 0; i < int'(N); i++) begin
        pat[2*i +: 2] = {b[i], (i == 0) ? 1'b0 : b[i-1]};
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      pr = pat[2*i +: 2];
      if (pr == 2'b10) exp_ops.push_back(1);
      if (pr == 2'b01) exp_ops.push_back(0);
    end
    exp_lat = 2 + 2 * int'(N) + exp_ops.size();
    use_dp = dp; fpat = pat; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b1;
    c = 0; nsh = 0; nar = 0; seen = 1'b0;
    while (!seen && c < 40) begin
      @(negedge clk);
      c++;
      start = b2b || (extra && (c == 3 || c == 7));
      n_checks++;
      if ({carga_m, carga_q, clr_q1} !== ((c == 1) ? 3'b111 : 3'b000)) begin
        n_fail++;
        $display("FAIL %s load_strobes c=%0d got=%b want=%b", name, c,
                 {carga_m, carga_q, clr_q1}, (c == 1) ? 3'b111 : 3'b000);
      end
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy c=%0d got=%b want=1", name, c, busy);
      end
      n_checks++;
      if (carga_a && desplaza) begin
        n_fail++;
        $display("FAIL %s load_shift_overlap c=%0d got=1 want=0", name, c);
      end
      if (c == 1) begin
        n_checks++;
        if ({carga_a, sel_suma, done} !== 3'b100) begin
          n_fail++;
          $display("FAIL %s load_cycle c=1 got=%b want=100", name, {carga_a, sel_suma, done});
        end
      end else if (carga_a) begin
        nar++;
        n_checks++;
        if (exp_ops.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_arith c=%0d got=arith want=none", name, c);
        end else if ({sel_suma, resta} !== {1'b1, exp_ops[0][0]}) begin
          n_fail++;
          $display("FAIL %s arith_op c=%0d got=%b want=%b", name, c, {sel_suma, resta},
                   {1'b1, exp_ops[0][0]});
          void'(exp_ops.pop_front());
        end else begin
          void'(exp_ops.pop_front());
        end
      end else begin
        n_checks++;
        if ({sel_suma, resta} !== 2'b00) begin
          n_fail++;
          $display("FAIL %s resta_idle c=%0d got=%b want=00", name, c, {sel_suma, resta});
        end
      end
      if (desplaza) nsh++;
      if (done) seen = 1'b1;
    end
    n_checks++;
    if (!seen || c != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency got=%0d want=%0d (done seen=%0b)", name, c, exp_lat, seen);
    end
    n_checks++;
    if (nsh != int'(N) || exp_ops.size() != 0) begin
      n_fail++;
      $display("FAIL %s iterations shifts=%0d want=%0d leftover_ops=%0d", name, nsh, N,
               exp_ops.size());
    end
    if (dp) begin
      prod  = $signed({dp_a, dp_q});
      eprod = $signed(a) * $signed(b);
      n_checks++;
      if (prod !== eprod) begin
        n_fail++;
        $display("FAIL %s product a=%0d b=%0d got=%0d want=%0d", name, $signed(a),
                 $signed(b), prod, eprod);
      end
    end
    if (b2b) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s b2b_idle busy got=%b want=0", name, busy);
      end
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (carga_m !== 1'b1) begin
        n_fail++;
        $display("FAIL %s b2b_reload carga_m got=%b want=1", name, carga_m);
      end
      wait_c = 0;
      while (done !== 1'b1 && wait_c < 40) begin
        @(negedge clk);
        wait_c++;
      end
      n_checks++;
      if (done !== 1'b1) begin
        n_fail++;
        $display("FAIL %s b2b_second_done timeout got=%b want=1", name, done);
      end
    end
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done} !== {1'b0, HOLD}) begin
        n_fail++;
        $display("FAIL %s post_fin k=%0d busy,done got=%b want=%b", name, k, {busy, done},
                 {1'b0, HOLD});
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; use_dp = 1'b0; fpat = '0; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (all_outs() !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b want=0", all_outs());
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (all_outs() !== 9'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset got=%b want=0", all_outs());
    end
  endtask

  task automatic test_directed();
    do_run("all_shift", 1'b0, 6'b000000, '0, '0, 1'b0, 1'b0);
    do_run("all_sub", 1'b0, 6'b101010, '0, '0, 1'b0, 1'b0);
    do_run("alternate", 1'b0, 6'b100001, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    int c, nar;
    use_dp = 1'b0; fpat = 6'b101010;
    @(negedge clk);
    start = 1'b1;
    c = 0; nar = 0;
    while (nar < 2 && c < 40) begin
      @(negedge clk);
      start = 1'b0;
      c++;
      if (carga_a && sel_suma) nar++;
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (all_outs() !== 9'd0 || nar != 2) begin
      n_fail++;
      $display("FAIL reset_mid_run outs got=%b want=0 (arith seen=%0d)", all_outs(), nar);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (all_outs() !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_no_resume got=%b want=0", all_outs());
    end
    do_run("after_reset", 1'b0, 6'b100001, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_start();
    do_run("ignored_start", 1'b0, 6'b011000, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_run("back_to_back", 1'b0, 6'b000110, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      do_run("rand_mult", 1'b1, '0, N'($urandom), N'($urandom), 1'($urandom), 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      do_run("rand_pat", 1'b0, (2*N)'($urandom), '0, '0, 1'($urandom), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_run();
    test_ignored_start();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
